// File: rtl/posit_div_core.sv
// Sequential posit32 (es=3) division core: restoring radix-2 mantissa divider
// with scale arithmetic, normalization, regime clamping and NaR/zero bypass.
module posit_div_core #(
    parameter int MW     = 32,
    parameter int K_BITS = 6,
    parameter int ES     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [K_BITS-1:0] k_a,
    input  logic [K_BITS-1:0] k_b,
    input  logic [ES-1:0]     exp_a,
    input  logic [ES-1:0]     exp_b,
    input  logic [MW-1:0]     mant_a,
    input  logic [MW-1:0]     mant_b,
    input  logic              zero_a,
    input  logic              nar_a,
    input  logic              zero_b,
    input  logic              nar_b,
    output logic              busy,
    output logic              done,
    output logic              sign_out,
    output logic [K_BITS-1:0] k_out,
    output logic [ES-1:0]     exp_out,
    output logic [MW-1:0]     mant_out,
    output logic              sticky,
    output logic              NAR,
    output logic              ZERO
);

    localparam int SW = 11;          // scale width
    localparam int QW = MW + 2;      // quotient bits: integer bit plus guard bits
    localparam int CW = 6;
    localparam logic [CW-1:0]     CNT_LAST = CW'(QW - 1);
    localparam logic signed [SW-1:0] K_MIN = -11'sd31;
    localparam logic signed [SW-1:0] K_MAX = 11'sd30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [MW-1:0]          mant_b_r;
    logic                   sign_r;
    logic signed [SW-1:0]   scale_r;
    logic [MW:0]            rem_r;
    logic [QW-1:0]          q_r;
    logic [CW-1:0]          cnt_r;

    logic                   busy_r;
    logic                   done_r;
    logic                   sign_out_r;
    logic [K_BITS-1:0]      k_out_r;
    logic [ES-1:0]          exp_out_r;
    logic [MW-1:0]          mant_out_r;
    logic                   sticky_r;
    logic                   nar_r;
    logic                   zero_r;

    logic                   special_nar_s;
    logic signed [SW-1:0]   scale_a_s;
    logic signed [SW-1:0]   scale_b_s;
    logic signed [SW-1:0]   scale_in_s;
    logic                   rem_ge_s;
    logic [MW:0]            rem_sub_s;
    logic [MW:0]            rem_next_s;
    logic signed [SW-1:0]   scale_adj_s;
    logic signed [SW-1:0]   k_full_s;
    logic [MW-1:0]          norm_mant_s;
    logic                   norm_sticky_s;
    logic                   rem_nz_s;

    // Operand scales (k*2^ES + exp) and the restoring-divider step
    always_comb begin
        special_nar_s = nar_a | nar_b | zero_b;
        scale_a_s     = $signed({{(SW-K_BITS-ES){k_a[K_BITS-1]}}, k_a, {ES{1'b0}}})
                      + $signed({{(SW-ES){1'b0}}, exp_a});
        scale_b_s     = $signed({{(SW-K_BITS-ES){k_b[K_BITS-1]}}, k_b, {ES{1'b0}}})
                      + $signed({{(SW-ES){1'b0}}, exp_b});
        scale_in_s    = scale_a_s - scale_b_s;
        rem_ge_s      = (rem_r >= {1'b0, mant_b_r});
        if (rem_ge_s) begin
            rem_sub_s = rem_r - {1'b0, mant_b_r};
        end else begin
            rem_sub_s = rem_r;
        end
        rem_next_s    = {rem_sub_s[MW-1:0], 1'b0};
    end

    // Normalization of the finished quotient and regime extraction
    always_comb begin
        rem_nz_s = (rem_r != {(MW+1){1'b0}});
        if (q_r[QW-1]) begin
            norm_mant_s   = q_r[QW-1:2];
            norm_sticky_s = q_r[1] | q_r[0] | rem_nz_s;
            scale_adj_s   = scale_r;
        end else begin
            norm_mant_s   = q_r[QW-2:1];
            norm_sticky_s = q_r[0] | rem_nz_s;
            scale_adj_s   = scale_r - 11'sd1;
        end
        k_full_s = scale_adj_s >>> ES;
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (special_nar_s || zero_a) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = DIV;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = NORM;
                end else begin
                    state_next_s = DIV;
                end
            end
            NORM:    state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, divider iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_b_r   <= {MW{1'b0}};
            sign_r     <= 1'b0;
            scale_r    <= {SW{1'b0}};
            rem_r      <= {(MW+1){1'b0}};
            q_r        <= {QW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            sign_out_r <= 1'b0;
            k_out_r    <= {K_BITS{1'b0}};
            exp_out_r  <= {ES{1'b0}};
            mant_out_r <= {MW{1'b0}};
            sticky_r   <= 1'b0;
            nar_r      <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mant_b_r <= mant_b;
                        sign_r   <= sign_a ^ sign_b;
                        scale_r  <= scale_in_s;
                        rem_r    <= {1'b0, mant_a};
                        q_r      <= {QW{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        nar_r    <= 1'b0;
                        zero_r   <= 1'b0;
                        // Bypass results are fully written here; normal results wait for NORM
                        if (special_nar_s || zero_a) begin
                            nar_r      <= special_nar_s;
                            zero_r     <= ~special_nar_s;
                            sign_out_r <= 1'b0;
                            k_out_r    <= {K_BITS{1'b0}};
                            exp_out_r  <= {ES{1'b0}};
                            mant_out_r <= {MW{1'b0}};
                            sticky_r   <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    rem_r <= rem_next_s;
                    q_r   <= {q_r[QW-2:0], rem_ge_s};
                    cnt_r <= cnt_r + 6'd1;
                end
                NORM: begin
                    sign_out_r <= sign_r;
                    mant_out_r <= norm_mant_s;
                    if (k_full_s < K_MIN) begin
                        k_out_r   <= K_MIN[K_BITS-1:0];
                        exp_out_r <= {ES{1'b0}};
                        sticky_r  <= 1'b0;
                    end else if (k_full_s > K_MAX) begin
                        k_out_r   <= K_MAX[K_BITS-1:0];
                        exp_out_r <= {ES{1'b0}};
                        sticky_r  <= 1'b0;
                    end else begin
                        k_out_r   <= k_full_s[K_BITS-1:0];
                        exp_out_r <= scale_adj_s[ES-1:0];
                        sticky_r  <= norm_sticky_s;
                    end
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_r == DONE);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sign_out = sign_out_r;
    assign k_out    = k_out_r;
    assign exp_out  = exp_out_r;
    assign mant_out = mant_out_r;
    assign sticky   = sticky_r;
    assign NAR      = nar_r;
    assign ZERO     = zero_r;

endmodule

// File: tb/tb_posit_div_core.sv
// Directed scoreboard bench for posit_div_core.
module tb_posit_div_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign_a = 1'b0, sign_b = 1'b0;
    logic [5:0]  k_a = 6'd0, k_b = 6'd0;
    logic [2:0]  exp_a = 3'd0, exp_b = 3'd0;
    logic [31:0] mant_a = 32'd0, mant_b = 32'd0;
    logic        zero_a = 1'b0, nar_a = 1'b0, zero_b = 1'b0, nar_b = 1'b0;
    logic        busy, done, sign_out, sticky, NAR, ZERO;
    logic [5:0]  k_out;
    logic [2:0]  exp_out;
    logic [31:0] mant_out;

    typedef struct {
        logic        sign;
        logic [5:0]  k;
        logic [2:0]  ex;
        logic [31:0] mant;
        logic        sticky;
        logic        nar;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    posit_div_core dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sign_a(sign_a), .sign_b(sign_b), .k_a(k_a), .k_b(k_b),
        .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
        .zero_a(zero_a), .nar_a(nar_a), .zero_b(zero_b), .nar_b(nar_b),
        .busy(busy), .done(done), .sign_out(sign_out), .k_out(k_out),
        .exp_out(exp_out), .mant_out(mant_out), .sticky(sticky),
        .NAR(NAR), .ZERO(ZERO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic [5:0] k, input logic [2:0] ex,
                                input logic [31:0] m, input logic st, input logic nr,
                                input logic zr, input int lat);
        exp_t e;
        e.sign = s; e.k = k; e.ex = ex; e.mant = m; e.sticky = st;
        e.nar = nr; e.zero = zr; e.lat = lat;
        return e;
    endfunction

    task automatic set_ops(input logic sa, input logic [5:0] ka, input logic [2:0] ea,
                           input logic [31:0] ma, input logic sbb, input logic [5:0] kb,
                           input logic [2:0] eb, input logic [31:0] mb,
                           input logic za, input logic na, input logic zb, input logic nb);
        sign_a = sa; k_a = ka; exp_a = ea; mant_a = ma;
        sign_b = sbb; k_b = kb; exp_b = eb; mant_b = mb;
        zero_a = za; nar_a = na; zero_b = zb; nar_b = nb;
    endtask

    // Start an operation, optionally re-pulse start mid-flight, then check the popped expectation
    task automatic run_op(input string tag, input exp_t e, input int glitch);
        int n;
        exp_t x;
        sb_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            start = (n == glitch);
            if (n == glitch) set_ops(1'b0, 6'd5, 3'd1, 32'hFFFFFFFF, 1'b0, 6'd0, 3'd0,
                                     32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        start = 1'b0;
        x = sb_q.pop_front();
        chk({tag, "_lat"},    64'(n),        64'(x.lat));
        chk({tag, "_sign"},   64'(sign_out), 64'(x.sign));
        chk({tag, "_k"},      64'(k_out),    64'(x.k));
        chk({tag, "_exp"},    64'(exp_out),  64'(x.ex));
        chk({tag, "_mant"},   64'(mant_out), 64'(x.mant));
        chk({tag, "_sticky"}, 64'(sticky),   64'(x.sticky));
        chk({tag, "_nar"},    64'(NAR),      64'(x.nar));
        chk({tag, "_zero"},   64'(ZERO),     64'(x.zero));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
        chk({tag, "_hold"}, 64'(mant_out), 64'(x.mant));
    endtask

    initial begin
        int n;
        #12;
        chk("reset_outs", 64'({busy, done, sign_out, k_out, exp_out, sticky, NAR, ZERO}), 64'd0);
        chk("reset_mant", 64'(mant_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_ops(0, 6'd0, 3'd0, 32'h80000000, 0, 6'd0, 3'd0, 32'h80000000, 0, 0, 0, 0);
        run_op("one_div_one", mk(0, 6'd0, 3'd0, 32'h80000000, 0, 0, 0, 36), -1);

        set_ops(0, 6'd0, 3'd0, 32'h80000000, 0, 6'd0, 3'd0, 32'hC0000000, 0, 0, 0, 0);
        run_op("one_div_1p5", mk(0, 6'h3F, 3'd7, 32'hAAAAAAAA, 1, 0, 0, 36), -1);

        set_ops(1, 6'd2, 3'd5, 32'hC0000000, 0, 6'd0, 3'd3, 32'h80000000, 0, 0, 0, 0);
        run_op("sign_scale", mk(1, 6'd2, 3'd2, 32'hC0000000, 0, 0, 0, 36), -1);

        set_ops(0, 6'd0, 3'd0, 32'hFFFFFFFF, 1, 6'd0, 3'd0, 32'h80000000, 0, 0, 0, 0);
        run_op("max_mant", mk(1, 6'd0, 3'd0, 32'hFFFFFFFF, 0, 0, 0, 36), -1);

        set_ops(1, 6'd3, 3'd0, 32'h80000000, 1, 6'd0, 3'd0, 32'h80000000, 0, 0, 1, 0);
        run_op("div_zero", mk(0, 6'd0, 3'd0, 32'd0, 0, 1, 0, 1), -1);

        set_ops(1, 6'd3, 3'd0, 32'h80000000, 0, 6'd0, 3'd0, 32'h80000000, 0, 1, 0, 0);
        run_op("nar_a", mk(0, 6'd0, 3'd0, 32'd0, 0, 1, 0, 1), -1);

        set_ops(1, 6'd3, 3'd0, 32'h80000000, 0, 6'd1, 3'd0, 32'h80000000, 1, 0, 0, 0);
        run_op("zero_a", mk(0, 6'd0, 3'd0, 32'd0, 0, 0, 1, 1), -1);

        set_ops(0, 6'd30, 3'd7, 32'h80000000, 0, 6'h21, 3'd0, 32'h80000000, 0, 0, 0, 0);
        run_op("sat_max", mk(0, 6'd30, 3'd0, 32'h80000000, 0, 0, 0, 36), -1);

        set_ops(0, 6'h21, 3'd0, 32'h80000000, 0, 6'd30, 3'd7, 32'h80000000, 0, 0, 0, 0);
        run_op("sat_min", mk(0, 6'h21, 3'd0, 32'h80000000, 0, 0, 0, 36), -1);

        set_ops(0, 6'd30, 3'd7, 32'h80000000, 0, 6'h21, 3'd0, 32'hC0000000, 0, 0, 0, 0);
        run_op("sat_sticky", mk(0, 6'd30, 3'd0, 32'hAAAAAAAA, 0, 0, 0, 36), -1);

        set_ops(0, 6'd1, 3'd4, 32'hC0000000, 1, 6'd0, 3'd0, 32'h80000000, 0, 0, 0, 0);
        run_op("glitch", mk(1, 6'd1, 3'd4, 32'hC0000000, 0, 0, 0, 36), 10);

        // Abort with reset in the middle of a divide
        set_ops(0, 6'd0, 3'd0, 32'h80000000, 0, 6'd0, 3'd0, 32'hC0000000, 0, 0, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 64'({busy, done, sign_out, k_out, exp_out, sticky, NAR, ZERO}), 64'd0);
        chk("abort_mant", 64'(mant_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        chk("abort_no_done", 64'(n), 64'd0);

        set_ops(0, 6'd0, 3'd0, 32'h80000000, 0, 6'd0, 3'd0, 32'hC0000000, 0, 0, 0, 0);
        run_op("after_reset", mk(0, 6'h3F, 3'd7, 32'hAAAAAAAA, 1, 0, 0, 36), -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/posit_div_core.md
Name: posit_div_core

Overview:
- Sequential division core for the posit32 (es=3) datapath; the inverse-direction counterpart of the multiply path.
- Input: decoded fields of dividend A and divisor B, as produced by the decoder stage.
- Output: quotient sign, regime k, exponent, normalized 32-bit mantissa and sticky bit, ready for round-off and encoding.
- Mantissa quotient uses a restoring radix-2 divider (one quotient bit per cycle). Special cases (NaR/zero) are resolved in one cycle.

Parameters:
MW, 32, mantissa width; hidden 1 at bit MW-1 for nonzero operands
K_BITS, 6, regime width, signed two's complement
ES, 3, exponent field width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
sign_a  input  1  dividend sign
sign_b  input  1  divisor sign
k_a  input  K_BITS  dividend regime (signed)
k_b  input  K_BITS  divisor regime (signed)
exp_a  input  ES  dividend exponent
exp_b  input  ES  divisor exponent
mant_a  input  MW  dividend mantissa 1.f, hidden bit at MW-1
mant_b  input  MW  divisor mantissa 1.f
zero_a  input  1  dividend is zero
nar_a  input  1  dividend is NaR
zero_b  input  1  divisor is zero
nar_b  input  1  divisor is NaR
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
sign_out  output  1  sign_a XOR sign_b
k_out  output  K_BITS  result regime, clamped to [-31,30]
exp_out  output  ES  result exponent
mant_out  output  MW  normalized quotient, hidden bit at MW-1
sticky  output  1  OR of all discarded quotient bits and nonzero final remainder
NAR  output  1  result is NaR
ZERO  output  1  result is zero

Behaviour:
- Reset: all outputs 0; FSM to IDLE; internal remainder, quotient and counter cleared. Reset mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, DIV, NORM, DONE.
- IDLE + start (edge 0):
  - Latch all inputs.
  - Compute scale = (k_a*8 + exp_a) - (k_b*8 + exp_b), 11-bit signed.
  - If nar_a | nar_b | zero_b: next state DONE with NAR=1, ZERO=0, mant_out=0, k_out=0, exp_out=0, sign_out=0.
  - Else if zero_a: next state DONE with ZERO=1, NAR=0, other fields 0.
  - Else: rem = {0, mant_a} (MW+1 bits), q=0, cnt=0, next state DIV.
- Special-case done rises after edge 1.
- DIV (edges 1..34, 34 iterations):
  - If rem >= {0, mant_b}: q bit = 1 and rem -= mant_b; else q bit = 0.
  - q shifts left by one, taking the new bit in at the LSB. rem shifts left by one.
  - After 34 bits, q[33] is the integer bit.
- NORM (edge 35):
  - If q[33]=1: mant_out = q[33:2]; sticky = q[1] | q[0] | (rem != 0); scale unchanged.
  - Else: mant_out = q[32:1]; sticky = q[0] | (rem != 0); scale = scale - 1.
  - k_out = scale >>> 3 (floor); exp_out = scale[2:0].
  - If k < -31: k_out = -31, exp_out = 0 (minpos).
  - If k > 30: k_out = 30, exp_out = 0 (maxpos).
  - In both clamp cases sticky is forced to 0.
- DONE: done = 1 for exactly one cycle (normal path: cycle after edge 36; i.e. done high 36 cycles after the start edge), then return to IDLE.
- busy = 1 in DIV, NORM and DONE.
- Outputs hold their values until the next accepted start; NAR/ZERO are cleared at the next accepted start.
- start while busy is ignored, with no effect on the in-flight operation.
- start held high continuously: a new operation is accepted on the first IDLE cycle after done.
- Result register and arithmetic widths: scale is 11-bit signed, with no overflow across the full k/exp input range.

Test Plan:
- 1.0/1.0: mant_a = mant_b = 0x80000000, k = 0, exp = 0 → done 36 cycles after start; mant_out = 0x80000000, k_out = 0, exp_out = 0, sticky = 0, NAR = ZERO = 0.
- 1.0/1.5: mant_b = 0xC0000000 → mant_out = 0xAAAAAAAA, k_out = -1, exp_out = 7, sticky = 1.
- Signs and scale: sign_a = 1, k_a = 2, exp_a = 5, mant_a = 0xC0000000 ÷ sign_b = 0, k_b = 0, exp_b = 3, mant_b = 0x80000000 → sign_out = 1, k_out = 2, exp_out = 2, mant_out = 0xC0000000, sticky = 0.
- Special cases (done next cycle, no DIV):
  - zero_b = 1 → NAR = 1.
  - nar_a = 1 → NAR = 1.
  - zero_a = 1 with a valid divisor → ZERO = 1.
- Saturation:
  - k_a = 30, exp_a = 7 ÷ k_b = -31, exp_b = 0, equal mantissas → k_out = 30, exp_out = 0, sticky = 0.
  - Swapped operands → k_out = -31, exp_out = 0.
- Control robustness:
  - start pulsed at cycle 10 of a running divide → ignored; original result correct.
  - rst_n low at cycle 20 → all outputs 0, no done.
  - Fresh start afterwards completes normally.
